// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory responder with one outstanding access,
// registered synchronous array and saturating completion counters.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic              wren_q, rsp_wr_q;
  logic [ADDR_W-1:0] addr_q, rsp_addr_q;
  logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              done;
  always_comb begin
    state_d = state_q;
    done = (state_q == RESP) && rsp_ready;
    if (state_q == IDLE && req_valid) state_d = ACCESS;
    if (state_q == ACCESS) state_d = RESP;
    if (done) state_d = IDLE;
    wr_cnt_d = wr_cnt_q + CNT_W'(done && rsp_wr_q && wr_cnt_q != '1);
    rd_cnt_d = rd_cnt_q + CNT_W'(done && !rsp_wr_q && rd_cnt_q != '1);
  end
  // Array has no reset; an async reset during ACCESS drops state to IDLE before the edge, so no write lands.
  always_ff @(posedge clock)
    if (state_q == ACCESS && wren_q) mem[addr_q] <= wdata_q;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q     <= IDLE;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_wr_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      if (state_q == IDLE && req_valid) begin
        wren_q  <= req_wren;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ACCESS) begin
        rsp_wr_q    <= wren_q;
        rsp_addr_q  <= addr_q;
        rsp_rdata_q <= wren_q ? wdata_q : mem[addr_q];
      end
    end
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_wr    = rsp_wr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
endmodule
